// File: rtl/barcode_pkg.sv
// rtl/barcode_pkg.sv - shared FSM type and frame constants for the bar serializer
// BARCODE_PARITY_EN adds the even-parity bar between the value field and the stop guard.
package barcode_pkg;

  localparam int GUARD_W = 3;
  localparam logic [GUARD_W-1:0] GUARD = 3'b101;

`ifdef BARCODE_PARITY_EN
  localparam int PARITY_BARS = 1;
  typedef enum logic [2:0] {IDLE, START, CODE, VALUE, PARITY, STOP, DONE} state_t;
`else
  localparam int PARITY_BARS = 0;
  typedef enum logic [2:0] {IDLE, START, CODE, VALUE, STOP, DONE} state_t;
`endif

  function automatic int frame_bars(input int code_w, input int value_w);
    return 2 * GUARD_W + code_w + value_w + PARITY_BARS;
  endfunction

endpackage

// File: rtl/bar_prescaler.sv
// rtl/bar_prescaler.sv - bar-time tick generator, pulses bit_tick on the last cycle of each bar
// Held in clear between frames so every bar, including the first, lasts exactly BIT_CYCLES.
module bar_prescaler #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/barcode_serializer.sv
// rtl/barcode_serializer.sv - framed serial bar output: guard, code, value, [parity], guard
// BARCODE_PARITY_EN enables the parity bar (38-bar frame); otherwise frames are 37 bars.
module barcode_serializer
  import barcode_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int CODE_W     = 25,
  parameter int VALUE_W    = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic [CODE_W-1:0]  CodeWord,
  input  logic [VALUE_W-1:0] ValueToPay,
  output logic               BarOut,
  output logic               BarValid,
  output logic               Busy,
  output logic               Done
);

  localparam int DATA_W = CODE_W + VALUE_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_W - 1);
  localparam logic [CNT_W-1:0] CODE_LAST  = CNT_W'(CODE_W - 1);
  localparam logic [CNT_W-1:0] VALUE_LAST = CNT_W'(VALUE_W - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_q;
  logic [GUARD_W-1:0] guard_sh;
  logic               bit_tick;
  logic               bar_last;
  logic               advance;
`ifdef BARCODE_PARITY_EN
  logic               parity_q;
`endif

  bar_prescaler #(.BIT_CYCLES(BIT_CYCLES)) u_prescaler (
    .clk      (Clk),
    .rst      (Reset),
    .clear    ((state == IDLE) || (state == DONE)),
    .bit_tick (bit_tick)
  );

  always_comb begin
    bar_last = 1'b0;
    case (state)
      START, STOP: bar_last = (bit_cnt == GUARD_LAST);
      CODE:        bar_last = (bit_cnt == CODE_LAST);
      VALUE:       bar_last = (bit_cnt == VALUE_LAST);
`ifdef BARCODE_PARITY_EN
      PARITY:      bar_last = 1'b1;
`endif
      default:     bar_last = 1'b0;
    endcase
  end

  assign advance  = bit_tick && bar_last;
  assign guard_sh = GUARD << bit_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (Load) state_nx = START;
      START:  if (advance) state_nx = CODE;
      CODE:   if (advance) state_nx = VALUE;
`ifdef BARCODE_PARITY_EN
      VALUE:  if (advance) state_nx = PARITY;
      PARITY: if (advance) state_nx = STOP;
`else
      VALUE:  if (advance) state_nx = STOP;
`endif
      STOP:   if (advance) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Payload is captured only on the accepting edge, so input changes mid-frame are invisible.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
`ifdef BARCODE_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && Load) begin
        shift_q <= {CodeWord, ValueToPay};
`ifdef BARCODE_PARITY_EN
        parity_q <= ^{CodeWord, ValueToPay};
`endif
      end else if (bit_tick && (state == CODE || state == VALUE)) begin
        shift_q <= shift_q << 1;
      end
      if (bit_tick)
        bit_cnt <= bar_last ? '0 : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    BarOut   = 1'b0;
    BarValid = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      START, STOP: begin
        BarOut   = guard_sh[GUARD_W-1];
        BarValid = 1'b1;
        Busy     = 1'b1;
      end
      CODE, VALUE: begin
        BarOut   = shift_q[DATA_W-1];
        BarValid = 1'b1;
        Busy     = 1'b1;
      end
`ifdef BARCODE_PARITY_EN
      PARITY: begin
        BarOut   = parity_q;
        BarValid = 1'b1;
        Busy     = 1'b1;
      end
`endif
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_barcode_serializer.sv
// tb/tb_barcode_serializer.sv - directed bench for barcode_serializer at BIT_CYCLES 1 and 4
// Expected frames follow the BARCODE_PARITY_EN setting of the build.
module tb_barcode_serializer;
  import barcode_pkg::*;

  localparam int CW = 25;
  localparam int VW = 6;
  localparam int NBARS = 2 * GUARD_W + CW + VW + PARITY_BARS;

  logic          clk = 1'b0;
  logic          rst;
  logic          load1, load4;
  logic [CW-1:0] code1, code4;
  logic [VW-1:0] val1, val4;
  logic          bar1, valid1, busy1, done1;
  logic          bar4, valid4, busy4, done4;
  logic          bar_m, valid_m, busy_m, done_m;
  bit            sel4;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  barcode_serializer #(.BIT_CYCLES(1), .CODE_W(CW), .VALUE_W(VW)) dut1 (
    .Clk(clk), .Reset(rst), .Load(load1), .CodeWord(code1), .ValueToPay(val1),
    .BarOut(bar1), .BarValid(valid1), .Busy(busy1), .Done(done1)
  );

  barcode_serializer #(.BIT_CYCLES(4), .CODE_W(CW), .VALUE_W(VW)) dut4 (
    .Clk(clk), .Reset(rst), .Load(load4), .CodeWord(code4), .ValueToPay(val4),
    .BarOut(bar4), .BarValid(valid4), .Busy(busy4), .Done(done4)
  );

  assign bar_m   = sel4 ? bar4   : bar1;
  assign valid_m = sel4 ? valid4 : valid1;
  assign busy_m  = sel4 ? busy4  : busy1;
  assign done_m  = sel4 ? done4  : done1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_frame(input logic [CW-1:0] c, input logic [VW-1:0] v);
`ifdef BARCODE_PARITY_EN
    return 64'({GUARD, c, v, ^{c, v}, GUARD});
`else
    return 64'({GUARD, c, v, GUARD});
`endif
  endfunction

  task automatic start_frame(input bit s, input logic [CW-1:0] c, input logic [VW-1:0] v);
    @(negedge clk);
    sel4 = s;
    if (s) begin code4 = c; val4 = v; load4 = 1'b1; end
    else   begin code1 = c; val1 = v; load1 = 1'b1; end
    @(posedge clk);
    #1;
    load1 = 1'b0;
    load4 = 1'b0;
  endtask

  // Called just after the accepting edge; samples every cycle of the frame plus the Done cycle.
  task automatic capture(input int bc, output logic [63:0] bars, output int busy_n,
                         output int bad, output logic done_ok);
    bars = '0;
    busy_n = 0;
    bad = 0;
    for (int c = 0; c < NBARS * bc; c++) begin
      @(negedge clk);
      if (c % bc == 0) bars = {bars[62:0], bar_m};
      else if (bar_m !== bars[0]) bad++;
      if (valid_m !== 1'b1) bad++;
      if (busy_m) busy_n++;
      if (done_m) bad++;
    end
    @(negedge clk);
    done_ok = done_m & ~busy_m & ~valid_m & ~bar_m;
  endtask

  logic [63:0]   bars;
  int            busy_n, bad, done_cnt;
  logic          done_ok;
  logic [CW-1:0] codes [4];

  initial begin
    rst = 1'b1;
    load1 = 1'b0; load4 = 1'b0;
    code1 = '0; code4 = '0; val1 = '0; val4 = '0;
    sel4 = 1'b0;
    #1;
    check("rst_dut1", {bar1, valid1, busy1, done1}, 4'b0000);
    check("rst_dut4", {bar4, valid4, busy4, done4}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: single-cycle bars, hand-built frame
    start_frame(0, 25'h0000001, 6'd12);
    capture(1, bars, busy_n, bad, done_ok);
`ifdef BARCODE_PARITY_EN
    check("t1_frame", bars, 64'({3'b101, 25'h0000001, 6'b001100, 1'b1, 3'b101}));
    check("t1_busy", busy_n, 38);
`else
    check("t1_frame", bars, 64'({3'b101, 25'h0000001, 6'b001100, 3'b101}));
    check("t1_busy", busy_n, 37);
`endif
    check("t1_hold", bad, 0);
    check("t1_done", done_ok, 1'b1);
    @(negedge clk);
    check("t1_done_pulse", {done1, valid1, busy1}, 3'b000);

    // 2: four cycles per bar, all-ones payload
    start_frame(1, 25'h1FFFFFF, 6'd63);
    capture(4, bars, busy_n, bad, done_ok);
`ifdef BARCODE_PARITY_EN
    check("t2_frame", bars, 64'({3'b101, 25'h1FFFFFF, 6'b111111, 1'b1, 3'b101}));
    check("t2_busy", busy_n, 152);
`else
    check("t2_frame", bars, 64'({3'b101, 25'h1FFFFFF, 6'b111111, 3'b101}));
    check("t2_busy", busy_n, 148);
`endif
    check("t2_hold", bad, 0);
    check("t2_done", done_ok, 1'b1);

    // 3: Load held high; payload changes right after each accept
    codes[0] = 25'h0123456; codes[1] = 25'h1555555; codes[2] = 25'h00F0F0F; codes[3] = 25'h1000001;
    @(negedge clk);
    sel4 = 1'b0;
    code1 = codes[0]; val1 = 6'd5; load1 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      code1 = codes[k+1];
      val1 = 6'(k + 40);
      capture(1, bars, busy_n, bad, done_ok);
      check($sformatf("t3_frame%0d", k), bars, exp_frame(codes[k], (k == 0) ? 6'd5 : 6'(k + 39)));
      check($sformatf("t3_done%0d", k), done_ok & (bad == 0), 1'b1);
      if (k == 2) load1 = 1'b0;
      @(negedge clk);
      check($sformatf("t3_gap%0d", k), {valid1, busy1, done1, bar1}, 4'b0000);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end

    // 4: asynchronous reset in bar 10, then a clean frame
    start_frame(1, 25'h1234567, 6'd33);
    repeat (42) @(negedge clk);
    check("t4_pre_valid", valid4, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t4_async_zero", {bar4, valid4, busy4, done4}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done4) done_cnt++;
    end
    check("t4_no_done", done_cnt, 0);
    start_frame(1, 25'h0F0F0F0, 6'd21);
    capture(4, bars, busy_n, bad, done_ok);
    check("t4_frame", bars, exp_frame(25'h0F0F0F0, 6'd21));
    check("t4_done", done_ok & (bad == 0), 1'b1);

    // 5: alternating code, zero value
    start_frame(0, 25'h0AAAAAA, 6'd0);
    capture(1, bars, busy_n, bad, done_ok);
`ifdef BARCODE_PARITY_EN
    check("t5_frame", bars, 64'({3'b101, 25'h0AAAAAA, 6'b000000, 1'b0, 3'b101}));
`else
    check("t5_frame", bars, 64'({3'b101, 25'h0AAAAAA, 6'b000000, 3'b101}));
`endif
    check("t5_done", done_ok & (bad == 0), 1'b1);

    // 6: Load during Done ignored, Load one cycle later accepted
    start_frame(0, 25'h1000000, 6'd1);
    capture(1, bars, busy_n, bad, done_ok);
    check("t6_done", done_ok, 1'b1);
    load1 = 1'b1;
    @(posedge clk);
    #1 load1 = 1'b0;
    @(negedge clk);
    check("t6_ignored", {valid1, busy1}, 2'b00);
    code1 = 25'h0000F0F; val1 = 6'd9; load1 = 1'b1;
    @(posedge clk);
    #1 load1 = 1'b0;
    capture(1, bars, busy_n, bad, done_ok);
    check("t6_frame", bars, exp_frame(25'h0000F0F, 6'd9));
    check("t6_done2", done_ok & (bad == 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
